// File: rtl/alu_acc_sequencer.sv
// Command sequencer for the 8-bit ALU: owns ACC, FLAGS and a small register file,
// issues one registered A/B/OPR per accepted command and retires the result a cycle later.
module alu_acc_sequencer #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4,
    parameter int RSEL_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_opr,
    input  logic              cmd_src,
    input  logic [RSEL_W-1:0] cmd_rsel,
    input  logic [DATA_W-1:0] cmd_imm,
    input  logic              cmd_st,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_opr,
    input  logic [DATA_W-1:0] alu_r,
    input  logic [3:0]        alu_flags,
    output logic [DATA_W-1:0] acc,
    output logic [3:0]        flags,
    output logic              done
);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t            state;
    logic [DATA_W-1:0] regfile [NREGS];
    logic              st_q;
    logic [RSEL_W-1:0] rsel_q;
    logic [DATA_W-1:0] rd_data;

    // Decoded read so an index beyond NREGS returns 0 instead of an X.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NREGS; i++)
            if (cmd_rsel == RSEL_W'(i))
                rd_data = regfile[i];
    end

    assign cmd_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            flags   <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_opr <= '0;
            done    <= 1'b0;
            st_q    <= 1'b0;
            rsel_q  <= '0;
            for (int i = 0; i < NREGS; i++)
                regfile[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_a   <= acc;
                        alu_b   <= cmd_src ? rd_data : cmd_imm;
                        // Stores park the ALU on passB; its result is discarded anyway.
                        alu_opr <= cmd_st ? 3'd0 : cmd_opr;
                        st_q    <= cmd_st;
                        rsel_q  <= cmd_rsel;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (st_q) begin
                        for (int i = 0; i < NREGS; i++)
                            if (rsel_q == RSEL_W'(i))
                                regfile[i] <= acc;
                    end else begin
                        acc   <= alu_r;
                        flags <= alu_flags;
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_acc_sequencer.sv
// Bench for alu_acc_sequencer: behavioural ALU on the alu_* port, directed cases,
// then randomized commands checked against an architectural ACC/FLAGS/regfile model.
module tb_alu_acc_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_src, cmd_st, done;
    logic [2:0] cmd_opr, alu_opr;
    logic [1:0] cmd_rsel;
    logic [7:0] cmd_imm, alu_a, alu_b, alu_r, acc;
    logic [3:0] alu_flags, flags;

    int nvec = 0;
    int nerr = 0;

    logic [7:0] acc_m;
    logic [3:0] flags_m;
    logic [7:0] regs_m [4];

    always #5 clk = ~clk;

    alu_acc_sequencer #(.DATA_W(8), .NREGS(4), .RSEL_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opr(cmd_opr), .cmd_src(cmd_src), .cmd_rsel(cmd_rsel),
        .cmd_imm(cmd_imm), .cmd_st(cmd_st),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opr(alu_opr),
        .alu_r(alu_r), .alu_flags(alu_flags),
        .acc(acc), .flags(flags), .done(done)
    );

    // ALU: returns {r, V, C, S, Z}. C is carry on add, borrow on sub, 0 otherwise;
    // shifts move by one place.
    function automatic logic [11:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
        logic [8:0] t;
        logic [7:0] r;
        logic       v, c;
        v = 1'b0; c = 1'b0; t = '0;
        case (op)
            3'd0: r = b;
            3'd1: begin
                t = {1'b0, a} - {1'b0, b}; r = t[7:0]; c = t[8];
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            3'd2: begin
                t = {1'b0, a} + {1'b0, b}; r = t[7:0]; c = t[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            3'd3: r = a ^ b;
            3'd4: r = {a[7], a[7:1]};
            3'd5: r = {a[6:0], 1'b0};
            3'd6: r = a & b;
            default: r = a | b;
        endcase
        return {r, v, c, r[7], (r == 8'd0)};
    endfunction

    always_comb {alu_r, alu_flags} = alu_f(alu_a, alu_b, alu_opr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        acc_m = '0; flags_m = '0;
        for (int i = 0; i < 4; i++) regs_m[i] = '0;
    endtask

    task automatic scramble();
        cmd_opr = 3'($urandom); cmd_src = 1'($urandom); cmd_rsel = 2'($urandom);
        cmd_imm = 8'($urandom); cmd_st = 1'($urandom);
    endtask

    // One full command: present at a negedge, check EXEC cycle, then the done cycle.
    task automatic issue(input logic [2:0] opr, input logic src, input logic [1:0] rsel,
                         input logic [7:0] imm, input logic st);
        logic [7:0] b;
        @(negedge clk);
        chk("ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_opr = opr; cmd_src = src; cmd_rsel = rsel;
        cmd_imm = imm; cmd_st = st;
        b = src ? regs_m[rsel] : imm;
        @(negedge clk);
        cmd_valid = 1'b0;
        scramble();
        chk("ready_exec", cmd_ready, 1'b0);
        chk("done_exec", done, 1'b0);
        chk("alu_a", alu_a, acc_m);
        chk("alu_b", alu_b, b);
        chk("alu_opr", alu_opr, st ? 3'd0 : opr);
        if (st) regs_m[rsel] = acc_m;
        else {acc_m, flags_m} = alu_f(acc_m, b, opr);
        @(negedge clk);
        chk("done_pulse", done, 1'b1);
        chk("ready_after", cmd_ready, 1'b1);
        chk("acc", acc, acc_m);
        chk("flags", flags, flags_m);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b1;
        cmd_opr = 3'd2; cmd_src = 1'b0; cmd_rsel = '0; cmd_imm = 8'h55; cmd_st = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_acc", acc, 8'h00);
        chk("rst_flags", flags, 4'h0);
        chk("rst_done", done, 1'b0);
        chk("rst_alu", {alu_a, alu_b, alu_opr}, 19'h0);
        cmd_valid = 1'b0;
        rst_n = 1'b1;

        // Overflowing add then overflowing sub.
        issue(3'd0, 1'b0, 2'd0, 8'h7F, 1'b0);
        issue(3'd2, 1'b0, 2'd0, 8'h01, 1'b0);
        chk("t1_acc", acc, 8'h80);
        chk("t1_flags", flags, 4'b1010);
        issue(3'd1, 1'b0, 2'd0, 8'h01, 1'b0);
        chk("t2_acc", acc, 8'h7F);
        chk("t2_flags", flags, 4'b1000);

        // Store leaves flags alone, register readback feeds B.
        issue(3'd0, 1'b0, 2'd0, 8'h5A, 1'b0);
        issue(3'd0, 1'b0, 2'd2, 8'h00, 1'b1);
        chk("t3_st_flags", flags, 4'b0000);
        chk("t3_st_acc", acc, 8'h5A);
        issue(3'd3, 1'b1, 2'd2, 8'hFF, 1'b0);
        chk("t3_acc", acc, 8'h00);
        chk("t3_flags", flags, 4'b0001);

        // Shifts.
        issue(3'd0, 1'b0, 2'd0, 8'h81, 1'b0);
        issue(3'd4, 1'b0, 2'd0, 8'h01, 1'b0);
        chk("t6_asr", {acc, flags}, {8'hC0, 4'b0010});
        issue(3'd5, 1'b0, 2'd0, 8'h01, 1'b0);
        chk("t6_shl", {acc, flags}, {8'h80, 4'b0010});

        // cmd_valid held high: accepts every other edge.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_opr = 3'd2; cmd_src = 1'b0; cmd_imm = 8'h01; cmd_st = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            chk("b2b_ready", cmd_ready, (k % 2) == 0);
            chk("b2b_done", done, (k > 0) && ((k % 2) == 0));
            if (k == 7) cmd_valid = 1'b0;
            if (k < 8) @(negedge clk);
        end
        for (int k = 0; k < 4; k++) {acc_m, flags_m} = alu_f(acc_m, 8'h01, 3'd2);
        chk("b2b_acc", acc, acc_m);
        chk("b2b_flags", flags, flags_m);

        // Reset during EXEC aborts the command.
        cmd_valid = 1'b1; cmd_opr = 3'd2; cmd_imm = 8'h10; cmd_src = 1'b0; cmd_st = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("abort_exec", cmd_ready, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        model_reset();
        chk("abort_done", done, 1'b0);
        chk("abort_acc", acc, 8'h00);
        chk("abort_flags", flags, 4'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", cmd_ready, 1'b1);
        chk("abort_done2", done, 1'b0);

        // Randomized commands with idle gaps and junk on cmd_* while idle.
        for (int n = 0; n < 60; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                scramble();
                chk("idle_acc", acc, acc_m);
                chk("idle_done", done, 1'b0);
            end
            issue(3'($urandom), 1'($urandom), 2'($urandom), 8'($urandom),
                  ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
